// File: rtl/wr_pack_arb.sv
// wr_pack_arb: round-robin arbiter for two narrow producers that packs RATIO beats per FIFO word.
// Optional feature: WR_PACK_FLUSH_EN pushes a partial word after FLUSH_CYCLES idle cycles.
module wr_pack_arb #(
    parameter int DIN_W        = 8,
    parameter int RATIO        = 4,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                   clk_wr,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [DIN_W-1:0]       req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DIN_W-1:0]       req1_data,
    output logic                   req1_ready,
    input  logic                   wfull,
    output logic                   winc,
    output logic [DIN_W*RATIO-1:0] wdata,
    output logic [1:0]             grant,
    output logic                   busy
);
    localparam int DOUT_W = DIN_W * RATIO;
    localparam int CNT_W  = $clog2(RATIO);

    if (RATIO < 2 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("wr_pack_arb: RATIO must be a power of two in 2..16");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("wr_pack_arb: FLUSH_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          grant_r, grant_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [DOUT_W-1:0]   buf_r, buf_s;
    logic                last_r, last_s;   // 1 when producer 1 was served last
    logic                busy_r;
    logic                beat_s;
    logic [DIN_W-1:0]    beat_data_s;
`ifdef WR_PACK_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
    logic [IDLE_W-1:0]   idle_r, idle_s;
`endif

    assign req0_ready = (state_r == ST_PACK) && grant_r[0];
    assign req1_ready = (state_r == ST_PACK) && grant_r[1];
    assign winc       = (state_r == ST_PUSH) && !wfull;
    assign wdata      = buf_r;
    assign grant      = grant_r;
    assign busy       = busy_r;

    // Select the accepted beat from the granted producer.
    always_comb begin
        beat_s      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        beat_data_s = {DIN_W{1'b0}};
        if (grant_r[1]) begin
            beat_data_s = req1_data;
        end else begin
            beat_data_s = req0_data;
        end
    end

    // Next-state, grant, pack-buffer and last-served computation.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        cnt_s   = cnt_r;
        buf_s   = buf_r;
        last_s  = last_r;
`ifdef WR_PACK_FLUSH_EN
        idle_s  = idle_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        grant_s = last_r ? 2'b01 : 2'b10;
                    end else if (req0_valid) begin
                        grant_s = 2'b01;
                    end else begin
                        grant_s = 2'b10;
                    end
                    cnt_s   = {CNT_W{1'b0}};
                    buf_s   = {DOUT_W{1'b0}};
`ifdef WR_PACK_FLUSH_EN
                    idle_s  = {IDLE_W{1'b0}};
`endif
                    state_s = ST_PACK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (beat_s) begin
                    buf_s[cnt_r*DIN_W +: DIN_W] = beat_data_s;
                    cnt_s = cnt_r + 1'b1;
`ifdef WR_PACK_FLUSH_EN
                    idle_s = {IDLE_W{1'b0}};
`endif
                    // The counter wraps to 0 exactly as the last lane is filled.
                    if (cnt_r == CNT_W'(RATIO - 1)) begin
                        state_s = ST_PUSH;
                    end else begin
                        state_s = ST_PACK;
                    end
`ifdef WR_PACK_FLUSH_EN
                end else if (idle_r == IDLE_W'(FLUSH_CYCLES - 1)) begin
                    // Saturate here; an empty buffer never flushes.
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_s = ST_PUSH;
                    end else begin
                        state_s = ST_PACK;
                    end
                end else begin
                    idle_s  = idle_r + 1'b1;
                    state_s = ST_PACK;
                end
`else
                end else begin
                    state_s = ST_PACK;
                end
`endif
            end
            ST_PUSH: begin
                if (!wfull) begin
                    last_s  = grant_r[1];
                    grant_s = 2'b00;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 2'b00;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
            buf_r   <= {DOUT_W{1'b0}};
            last_r  <= 1'b1;
            busy_r  <= 1'b0;
`ifdef WR_PACK_FLUSH_EN
            idle_r  <= {IDLE_W{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            cnt_r   <= cnt_s;
            buf_r   <= buf_s;
            last_r  <= last_s;
            busy_r  <= (state_s != ST_IDLE);
`ifdef WR_PACK_FLUSH_EN
            idle_r  <= idle_s;
`endif
        end
    end
endmodule
